// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU ops.
// Revision    : 1.0  initial release
// ============================================================================
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOP,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOUT
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_p_q, hi_p_d, lo_p_q, lo_p_d;

  logic        is_mul, is_div, is_mac, mul_signed, div_signed, launch;
  logic [63:0] ext_a, ext_b, prod, result;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
`endif

  // Operation decode and datapath
  always_comb begin
    is_mul     = (MDUOP == OP_MULT) || (MDUOP == OP_MULTU);
    is_div     = (MDUOP == OP_DIV)  || (MDUOP == OP_DIVU);
    mul_signed = (MDUOP == OP_MULT);
    div_signed = (MDUOP == OP_DIV);
`ifdef MDU_MADD_EN
    is_mac     = (MDUOP == OP_MADD) || (MDUOP == OP_MADDU) ||
                 (MDUOP == OP_MSUB) || (MDUOP == OP_MSUBU);
    mul_signed = mul_signed || (MDUOP == OP_MADD) || (MDUOP == OP_MSUB);
`else
    is_mac     = 1'b0;
`endif
    launch = start && !busy_q && (is_mul || is_div || is_mac);

    // Low 64 bits of an extended product are correct for both signednesses
    ext_a = mul_signed ? {{32{A[31]}}, A} : {32'b0, A};
    ext_b = mul_signed ? {{32{B[31]}}, B} : {32'b0, B};
    prod  = ext_a * ext_b;

    // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow case
    a_mag = (div_signed && A[31]) ? -A : A;
    b_mag = (div_signed && B[31]) ? -B : B;
    q_mag = (B == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag = (B == 32'd0) ? 32'd0 : a_mag % b_mag;
    quo   = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem   = (div_signed && A[31]) ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
    acc = ((MDUOP == OP_MSUB) || (MDUOP == OP_MSUBU)) ? ({hi_q, lo_q} - prod)
                                                      : ({hi_q, lo_q} + prod);
`endif

    if (is_div) begin
      // Divide by zero commits the current HI/LO, which nothing can alter while busy
      result = (B == 32'd0) ? {hi_q, lo_q} : {rem, quo};
`ifdef MDU_MADD_EN
    end else if (is_mac) begin
      result = acc;
`endif
    end else begin
      result = prod;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_p_d = hi_p_q;
    lo_p_d = lo_p_q;
    if (cnt_q != '0) begin
      if (cnt_q == CNT_W'(1)) begin
        hi_d = hi_p_q;
        lo_d = lo_p_q;
      end
      cnt_d = cnt_q - CNT_W'(1);
    end else if (launch) begin
      cnt_d  = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      hi_p_d = result[63:32];
      lo_p_d = result[31:0];
    end else if (MDUOP == OP_MTHI) begin
      hi_d = A;
    end else if (MDUOP == OP_MTLO) begin
      lo_d = A;
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      hi_p_q <= '0;
      lo_p_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_p_q <= hi_p_d;
      lo_p_q <= lo_p_d;
    end
  end

  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOUT = (MDUOP == OP_MFHI) ? hi_q :
                  (MDUOP == OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl (directed plus random ops).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  MDUOP = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO, MDUOUT;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural HI/LO plus the outstanding operation
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_php = 32'd0, m_plo = 32'd0;
  int          m_left = 0;
  bit          m_keep = 1'b0;
  logic [31:0] last_mdu;

  mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOP(MDUOP), .start(start),
    .busy(busy), .HI(HI), .LO(LO), .MDUOUT(MDUOUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_launch(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  function automatic void ref_result(input logic [3:0] op, input logic [31:0] a, b,
                                     output logic [31:0] rh, rl, output bit keep);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    keep = 1'b0;
    p = 64'd0;
    rh = m_hi;
    rl = m_lo;
    case (op)
      4'd1:  p = sa * sb;
      4'd2:  p = ua * ub;
      4'd9:  p = {m_hi, m_lo} + 64'(sa * sb);
      4'd10: p = {m_hi, m_lo} + ua * ub;
      4'd11: p = {m_hi, m_lo} - 64'(sa * sb);
      4'd12: p = {m_hi, m_lo} - ua * ub;
      default: p = 64'd0;
    endcase
    if (op == 4'd3 || op == 4'd4) begin
      if (b == 32'd0) begin
        keep = 1'b1;
      end else begin
        if (op == 4'd3) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        rl = q[31:0];
        rh = r[31:0];
      end
    end else begin
      rh = p[63:32];
      rl = p[31:0];
    end
  endfunction

  function automatic void model_edge(input bit rst, input logic [3:0] op,
                                     input logic [31:0] a, b, input bit st);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_php = 0; m_plo = 0; m_left = 0; m_keep = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_keep) begin
        m_hi = m_php;
        m_lo = m_plo;
      end
    end else if (st && is_launch(op)) begin
      ref_result(op, a, b, m_php, m_plo, m_keep);
      m_left = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
    end else if (op == 4'd7) begin
      m_hi = a;
    end else if (op == 4'd8) begin
      m_lo = a;
    end
  endfunction

  task automatic cyc(input bit rst, input logic [3:0] op, input logic [31:0] a, b, input bit st);
    logic [31:0] exp_mdu;
    @(negedge clk);
    reset = rst; MDUOP = op; A = a; B = b; start = st;
    #1;
    exp_mdu = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    last_mdu = MDUOUT;
    chk("mduout", MDUOUT, exp_mdu);
    @(posedge clk);
    model_edge(rst, op, a, b, st);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 4'd0, $urandom, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    cyc(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    cyc(1'b0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(4);
    chk("mult_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    cyc(1'b0, 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    cyc(1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(9);
    chk("div_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    cyc(1'b0, 4'd4, 32'd7, 32'd2, 1'b1);
    idle(10);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    cyc(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(10);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    cyc(1'b0, 4'd7, 32'h1234, 32'd0, 1'b0);
    cyc(1'b0, 4'd8, 32'h5678, 32'd0, 1'b0);
    chk("mthi", HI, 32'h1234);
    chk("mtlo", LO, 32'h5678);
    cyc(1'b0, 4'd3, 32'd99, 32'd0, 1'b1);
    idle(10);
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'h5678);

    cyc(1'b0, 4'd1, 32'd6, 32'd7, 1'b1);
    cyc(1'b0, 4'd3, 32'd100, 32'd5, 1'b1);
    cyc(1'b0, 4'd8, 32'hDEAD, 32'd0, 1'b0);
    idle(2);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("ign_busy_fall", {31'd0, busy}, 32'd0);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd42);

    cyc(1'b0, 4'd7, 32'hAAAA, 32'd0, 1'b0);
    cyc(1'b0, 4'd3, 32'd100, 32'd3, 1'b1);
    idle(1);
    cyc(1'b0, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("mfhi_busy", last_mdu, 32'hAAAA);
    cyc(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    idle(12);
    chk("abort_nocommit_lo", LO, 32'd0);

    cyc(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
    cyc(1'b0, 4'd10, 32'd1, 32'd1, 1'b1);
`ifdef MDU_MADD_EN
    chk("maddu_busy", {31'd0, busy}, 32'd1);
    idle(5);
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
`else
    chk("maddu_busy", {31'd0, busy}, 32'd0);
    idle(5);
    chk("maddu_hi", HI, 32'd0);
    chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 79) == 0), 4'($urandom_range(0, 15)), pick(), pick(),
          ($urandom_range(0, 2) != 0));
    end
    idle(DIV_LAT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the P6 pipeline; sits in the E stage alongside the ALU.
- Accepts one start pulse, models fixed latency with a countdown, and raises busy so hazard logic can stall mult/div/mfhi/mflo/mthi/mtlo in D.
- Commits results to HI/LO when the countdown finishes. Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (>=1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- A  input  32  rs operand
- B  input  32  rt operand
- MDUOP  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others NONE
- start  input  1  one-cycle launch qualifier for MDUOP 1-4
- busy  output  1  countdown active
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- MDUOUT  output  32  read data for MFHI/MFLO

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset dominates all other inputs: HI=0, LO=0, cnt=0, busy=0, pending regs=0. Reset mid-operation aborts the operation with no HI/LO commit.
- Busy: busy = (cnt != 0), driven from a register. No combinational path from start to busy.
- Launch: on an edge with start=1, busy=0 and MDUOP in 1..4:
  - compute the result into hi_p/lo_p;
  - cnt <= MULT_LAT for MULT/MULTU, DIV_LAT for DIV/DIVU.
- Countdown: each edge with cnt>1 gives cnt <= cnt-1. On the edge with cnt==1, HI<=hi_p, LO<=lo_p and cnt<=0.
- Latency: busy is high for exactly LAT cycles after the launch edge. New HI/LO are visible in the cycle busy first reads 0.
- start while busy: ignored, with no effect on cnt or pending regs. start with MDUOP outside 1..4: ignored.
- MULT: {HI,LO} = signed A * signed B (64-bit). MULTU: unsigned 64-bit product.
- DIV: LO = A/B, HI = A%B, signed, quotient truncated toward zero, remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: the full DIV_LAT busy period still runs. At completion HI and LO keep their prior values.
- MTHI/MTLO: when busy=0, the edge writes A to HI or LO. Ignored while busy (start is not required).
- A launch and an MT* on the same edge cannot occur, because the op field holds one opcode.
- MDUOUT (combinational): HI when MDUOP=5, LO when MDUOP=6, else 0. It returns the committed value; during busy that is the old value, and hazard logic must stall.
- cnt width: enough bits for max(MULT_LAT, DIV_LAT).

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, these ops are added, treated as multiply class (MULT_LAT):
  - 9 MADD: {HI,LO} += signed A*B
  - 10 MADDU: {HI,LO} += unsigned A*B
  - 11 MSUB: {HI,LO} -= signed A*B
  - 12 MSUBU: {HI,LO} -= unsigned A*B
- Accumulation uses the HI/LO values at the launch edge, with 64-bit modular wrap.
- When undefined, opcodes 9-12 are treated as NONE (start ignored, MDUOUT=0).

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 with start -> busy high 5 cycles; after it falls, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x1234 and MTLO A=0x5678 while idle -> HI=0x1234, LO=0x5678. DIV with B=0 -> busy 10 cycles, then HI/LO unchanged.
- MULT launched, then start=1 with DIV at cycle 2, plus MTLO during busy -> both ignored. Completion writes the MULT result; busy falls after exactly 5 cycles.
- Reset asserted at cycle 3 of a DIV -> next cycle busy=0, HI=LO=0, with no later commit. MFHI (MDUOP=5) during a busy period returns the pre-launch HI.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0. Without the macro, the same stimulus leaves HI/LO unchanged and busy stays 0.
